// File: rtl/ifetch_resp.sv
// rtl/ifetch_resp.sv - fetch address issue, in-flight PC tracking and instruction buffer toward decode
//
// Optional feature macro: IFETCH_BYPASS_EN (same-cycle presentation of a response into an empty buffer)
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   pc_address, pc_valid        fetch address from the PC and its valid
//   flush                       redirect; kills buffered and in-flight fetches
//   stall_o                     fetch address not taken this cycle, PC must hold
//   inst_req, inst_addr         memory request valid / word-aligned address
//   inst_addr_ok                memory accepted the request
//   inst_rdata, inst_data_ok    in-order memory response
//   inst_valid, inst_data,      buffer head toward decode (data, PC, address-error flag)
//   inst_pc, inst_adel
//   decode_ready                decode pops the head when inst_valid & decode_ready
module ifetch_resp #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_address,
  input  logic        pc_valid,
  input  logic        flush,
  output logic        stall_o,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_adel,
  input  logic        decode_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = CW + OW + 1;

  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
  logic          r_fifo_adel [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] r_discard;
  logic [31:0]   r_pcq [MAX_OUTSTANDING];
  logic [QW-1:0] r_pcq_wptr;
  logic [QW-1:0] r_pcq_rptr;

  logic [SW-1:0] w_used;
  logic          w_space_ok;
  logic          w_aligned;
  logic          w_out_room;
  logic          w_discard_zero;
  logic          w_req_acc;
  logic          w_resp;
  logic          w_adel_wr;
  logic          w_fifo_empty;
  logic          w_fifo_pop;
  logic          w_byp;
  logic          w_byp_take;
  logic          w_push;
  logic [31:0]   w_push_data;
  logic [31:0]   w_push_pc;
  logic [31:0]   w_head_pc;
  logic [OW-1:0] w_out_next;

  // Slots already reserved: buffered entries plus responses that will actually be kept.
  assign w_used         = SW'(r_count) + SW'(r_outstanding) - SW'(r_discard);
  assign w_space_ok     = w_used < SW'(FIFO_DEPTH);
  assign w_aligned      = (pc_address[1:0] == 2'b00);
  assign w_out_room     = r_outstanding < OW'(MAX_OUTSTANDING);
  assign w_discard_zero = (r_discard == '0);
  assign w_fifo_empty   = (r_count == '0);
  assign w_head_pc      = r_pcq[r_pcq_rptr];

  assign inst_req  = pc_valid & ~flush & w_aligned & w_space_ok & w_out_room;
  assign inst_addr = {pc_address[31:2], 2'b00};
  assign w_req_acc = inst_req & inst_addr_ok;

  // A response is kept only when nothing is pending discard and no redirect is happening.
  assign w_resp    = inst_data_ok & w_discard_zero & ~flush;
  // The address-error entry shares the single write port with responses; the response wins.
  assign w_adel_wr = pc_valid & ~flush & ~w_aligned & w_space_ok & ~w_resp;
  assign stall_o   = pc_valid & ~flush & ~(w_req_acc | w_adel_wr);

`ifdef IFETCH_BYPASS_EN
  assign w_byp = w_fifo_empty & w_resp;
`else
  assign w_byp = 1'b0;
`endif

  always_comb begin
    inst_valid = ~w_fifo_empty | w_byp;
    inst_data  = 32'h0;
    inst_pc    = 32'h0;
    inst_adel  = 1'b0;
    if (!w_fifo_empty) begin
      inst_data = r_fifo_data[r_rptr];
      inst_pc   = r_fifo_pc[r_rptr];
      inst_adel = r_fifo_adel[r_rptr];
    end else if (w_byp) begin
      inst_data = inst_rdata;
      inst_pc   = w_head_pc;
    end
  end

  assign w_fifo_pop  = ~w_fifo_empty & decode_ready;
  assign w_byp_take  = w_byp & decode_ready;
  assign w_push      = (w_resp & ~w_byp_take) | w_adel_wr;
  assign w_push_data = w_adel_wr ? 32'h0 : inst_rdata;
  assign w_push_pc   = w_adel_wr ? pc_address : w_head_pc;
  assign w_out_next  = r_outstanding + OW'(w_req_acc) - OW'(inst_data_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_pcq_wptr    <= '0;
      r_pcq_rptr    <= '0;
    end else begin
      if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_fifo_data[r_wptr] <= w_push_data;
          r_fifo_pc[r_wptr]   <= w_push_pc;
          r_fifo_adel[r_wptr] <= w_adel_wr;
          r_wptr              <= r_wptr + PW'(1);
        end
        if (w_fifo_pop) begin
          r_rptr <= r_rptr + PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_fifo_pop);
      end

      // The PC queue stays in lockstep with the memory, even across flushes,
      // so discarded responses still retire their queue entry.
      if (w_req_acc) begin
        r_pcq[r_pcq_wptr] <= inst_addr;
        r_pcq_wptr <= (r_pcq_wptr == QW'(MAX_OUTSTANDING - 1)) ? '0 : r_pcq_wptr + QW'(1);
      end
      if (inst_data_ok) begin
        r_pcq_rptr <= (r_pcq_rptr == QW'(MAX_OUTSTANDING - 1)) ? '0 : r_pcq_rptr + QW'(1);
      end

      r_outstanding <= w_out_next;
      if (flush) begin
        r_discard <= w_out_next;
      end else if (inst_data_ok && !w_discard_zero) begin
        r_discard <= r_discard - OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && inst_data_ok) begin
      assert (r_outstanding != '0);
    end
  end

endmodule

// File: tb/tb_ifetch_resp.sv
// tb/tb_ifetch_resp.sv - directed and random checks of ifetch_resp against a queue-based reference model
module tb_ifetch_resp;

  localparam int D = 4;
  localparam int M = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_address;
  logic        pc_valid;
  logic        flush;
  logic        stall_o;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_adel;
  logic        decode_ready;

  ifetch_resp #(.FIFO_DEPTH(D), .MAX_OUTSTANDING(M)) dut (
    .clk(clk), .rst(rst),
    .pc_address(pc_address), .pc_valid(pc_valid), .flush(flush),
    .stall_o(stall_o),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_adel(inst_adel), .decode_ready(decode_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        adel;
  } ent_t;

  ent_t        fq[$];      // expected buffer contents toward decode
  logic [31:0] pend[$];    // expected in-flight fetch PCs, oldest first
  int          disc;       // responses still to be dropped
  logic [31:0] mem_q[$];   // memory side: requests it has accepted
  bit          dok_en;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h24080001;
    return (a ^ 32'h13579BDF) + 32'h1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int   live, space;
    bit   al, e_req, resp, adw, acc, e_stall, byp, e_valid;
    ent_t head;
    inst_data_ok = !rst && dok_en && (mem_q.size() > 0);
    inst_rdata   = inst_data_ok ? mem_word(mem_q[0]) : 32'h0;
    #1;
    if (rst) begin
      fq.delete();
      pend.delete();
      disc = 0;
      mem_q.delete();
    end else begin
      live    = pend.size() - disc;
      space   = D - fq.size() - live;
      al      = (pc_address[1:0] == 2'b00);
      e_req   = pc_valid && !flush && al && space > 0 && pend.size() < M;
      resp    = inst_data_ok && disc == 0 && !flush;
      adw     = pc_valid && !flush && !al && space > 0 && !resp;
      acc     = al ? (e_req && inst_addr_ok) : adw;
      e_stall = pc_valid && !flush && !acc;
`ifdef IFETCH_BYPASS_EN
      byp = (fq.size() == 0) && resp;
`else
      byp = 1'b0;
`endif
      e_valid = (fq.size() > 0) || byp;
      if (fq.size() > 0) head = fq[0];
      else if (byp)      head = '{data: inst_rdata, pc: pend[0], adel: 1'b0};
      else               head = '{data: 32'h0, pc: 32'h0, adel: 1'b0};

      chk("stall_o", 32'(stall_o), 32'(e_stall));
      chk("inst_req", 32'(inst_req), 32'(e_req));
      if (e_req) chk("inst_addr", inst_addr, {pc_address[31:2], 2'b00});
      chk("inst_valid", 32'(inst_valid), 32'(e_valid));
      chk("inst_data", inst_data, head.data);
      chk("inst_pc", inst_pc, head.pc);
      chk("inst_adel", 32'(inst_adel), 32'(head.adel));

      if (flush) fq.delete();
      else begin
        if (fq.size() > 0 && decode_ready) fq.delete(0);
        if (resp && !(byp && decode_ready)) fq.push_back('{data: inst_rdata, pc: pend[0], adel: 1'b0});
        if (adw) fq.push_back('{data: 32'h0, pc: pc_address, adel: 1'b1});
      end
      if (inst_data_ok) begin
        if (!flush && disc > 0) disc--;
        pend.delete(0);
      end
      if (e_req && inst_addr_ok) pend.push_back({pc_address[31:2], 2'b00});
      if (flush) disc = pend.size();

      if (inst_data_ok) mem_q.delete(0);
      if (inst_req && inst_addr_ok) mem_q.push_back(inst_addr);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(bit pv, logic [31:0] pc, bit fl, bit aok, bit dk, bit rdy);
    pc_valid     = pv;
    pc_address   = pc;
    flush        = fl;
    inst_addr_ok = aok;
    dok_en       = dk;
    decode_ready = rdy;
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    pc_valid = 0; pc_address = 0; flush = 0; inst_addr_ok = 0;
    inst_rdata = 0; inst_data_ok = 0; decode_ready = 0; dok_en = 0;
    disc = 0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;

    // reset state, then a single fetch answered two cycles later
    drive(0, 32'h0, 0, 0, 0, 1);
    drive(1, 32'hBFC00000, 0, 1, 0, 1);
    drive(0, 32'h0, 0, 0, 0, 1);
    drive(0, 32'h0, 0, 0, 1, 1);
`ifndef IFETCH_BYPASS_EN
    #1;
    chk("t1_valid", 32'(inst_valid), 32'd1);
    chk("t1_pc", inst_pc, 32'hBFC00000);
    chk("t1_data", inst_data, 32'h24080001);
`endif
    drive(0, 32'h0, 0, 0, 0, 1);

    // memory refuses for three cycles
    repeat (3) drive(1, 32'hBFC00004, 0, 0, 0, 1);
    drive(1, 32'hBFC00004, 0, 1, 0, 1);
    repeat (3) drive(0, 32'h0, 0, 0, 1, 1);

    // back-pressure: decode stalled until the buffer is full of reservations
    repeat (8) drive(1, 32'hBFC00100, 0, 1, 1, 0);
    #1;
    chk("bp_req", 32'(inst_req), 32'd0);
    chk("bp_stall", 32'(stall_o), 32'd1);
    drive(1, 32'hBFC00100, 0, 1, 1, 1);
    repeat (3) drive(1, 32'hBFC00100, 0, 1, 1, 0);
    repeat (8) drive(0, 32'h0, 0, 0, 1, 1);

    // flush with two in flight and one buffered
    drive(1, 32'hBFC00200, 0, 1, 0, 0);
    drive(1, 32'hBFC00204, 0, 1, 1, 0);
    drive(1, 32'hBFC00208, 0, 1, 0, 0);
    drive(0, 32'h0, 1, 0, 0, 0);
    repeat (2) drive(0, 32'h0, 0, 0, 1, 0);
    #1;
    chk("fl_empty", 32'(inst_valid), 32'd0);
    drive(1, 32'hBFC00380, 0, 1, 0, 1);
    drive(0, 32'h0, 0, 0, 1, 0);
    #1;
    chk("fl_pc", inst_pc, 32'hBFC00380);
    chk("fl_data", inst_data, mem_word(32'hBFC00380));
    drive(0, 32'h0, 0, 0, 0, 1);

    // misaligned fetch becomes an address-error entry
    drive(1, 32'hBFC00002, 0, 1, 0, 0);
    #1;
    chk("adel_flag", 32'(inst_adel), 32'd1);
    chk("adel_pc", inst_pc, 32'hBFC00002);
    chk("adel_data", inst_data, 32'h0);
    drive(0, 32'h0, 0, 0, 0, 1);

    // reset with one request outstanding, then a fresh fetch
    drive(1, 32'hBFC00400, 0, 1, 0, 1);
    rst = 1'b1;
    drive(0, 32'h0, 0, 0, 0, 1);
    rst = 1'b0;
    drive(0, 32'h0, 0, 0, 0, 1);
    drive(1, 32'hBFC00410, 0, 1, 0, 1);
    drive(0, 32'h0, 0, 0, 1, 1);
    drive(0, 32'h0, 0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc = $urandom;
      if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
      rst = ($urandom_range(0, 499) == 0);
      drive($urandom_range(0, 3) != 0, pc, $urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 6);
    end
    rst = 1'b0;
    repeat (10) drive(0, 32'h0, 0, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
